// File: rtl/sd_cache_lock_arbiter_pkg.sv
// Shared types and defaults for the SD cache lock arbiter slice.
package sd_cache_lock_pkg;

  localparam int unsigned DEFAULT_NUM_REQ        = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    HELD = 2'd2,
    REL  = 2'd3
  } state_t;

endpackage

// File: rtl/sd_cache_lock_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import sd_cache_lock_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int unsigned       j;
    logic [IDX_W-1:0]  k;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    k     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      k = IDX_W'(j);
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/sd_cache_lock_arbiter.sv
// Round-robin arbiter in front of the SD cache manager lock handshake.
// Optional forced release after TIMEOUT_CYCLES held cycles: define LOCK_TIMEOUT_EN.
module sd_cache_lock_arbiter
  import sd_cache_lock_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int unsigned OWNER_W        = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] rel_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [OWNER_W-1:0] owner_o,
  output logic               owner_valid_o,
  output logic               lock_acquire_o,
  output logic               lock_release_o,
  input  logic               lock_i,
  input  logic               unlock_i,
  output logic               timeout_o
);

  state_t             state, state_nxt;
  logic [OWNER_W-1:0] winner;
  logic [OWNER_W-1:0] ptr;
  logic [OWNER_W-1:0] pick_idx;
  logic               pick_valid;
  logic               timeout_hit;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (OWNER_W)
  ) u_rr_arbiter (
    .req   (req_i),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // An owner release in the expiry cycle is an ordinary release, not a timeout.
  assign timeout_hit = (state == HELD) && !rel_i[winner] &&
                       (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state == HELD) hold_cnt <= hold_cnt + CNT_W'(1);
      else               hold_cnt <= '0;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      winner <= '0;
      ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) winner <= pick_idx;
      if (state == ACQ && lock_i) begin
        ptr <= (winner == OWNER_W'(NUM_REQ - 1)) ? '0 : winner + OWNER_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_o          = '0;
    owner_o        = '0;
    owner_valid_o  = 1'b0;
    lock_acquire_o = 1'b0;
    lock_release_o = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = ACQ;
      end
      ACQ: begin
        lock_acquire_o = 1'b1;
        // A manager ack wins over a same-cycle request drop: the lock is already taken.
        if (lock_i)              state_nxt = HELD;
        else if (!req_i[winner]) state_nxt = IDLE;
      end
      HELD: begin
        gnt_o[winner] = 1'b1;
        owner_o       = winner;
        owner_valid_o = 1'b1;
        if (rel_i[winner] || timeout_hit) state_nxt = REL;
      end
      REL: begin
        owner_o        = winner;
        owner_valid_o  = 1'b1;
        lock_release_o = 1'b1;
        if (unlock_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_cache_lock_arbiter.sv
// Scoreboard bench for sd_cache_lock_arbiter; grant events checked by a negedge monitor.
module tb_sd_cache_lock_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_i;
  logic [NREQ-1:0] rel_i;
  logic [NREQ-1:0] gnt_o;
  logic [1:0]      owner_o;
  logic            owner_valid_o;
  logic            lock_acquire_o;
  logic            lock_release_o;
  logic            lock_i;
  logic            unlock_i;
  logic            timeout_o;
  logic            block_lock;

  typedef struct {
    logic [1:0]      owner;
    logic [NREQ-1:0] gnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;
  int   n_checks   = 0;
  int   n_fail     = 0;

  sd_cache_lock_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .rel_i          (rel_i),
    .gnt_o          (gnt_o),
    .owner_o        (owner_o),
    .owner_valid_o  (owner_valid_o),
    .lock_acquire_o (lock_acquire_o),
    .lock_release_o (lock_release_o),
    .lock_i         (lock_i),
    .unlock_i       (unlock_i),
    .timeout_o      (timeout_o)
  );

  always #5 clk = ~clk;

  // Manager model: accepts acquires unless blocked, accepts every release.
  assign lock_i   = lock_acquire_o & ~block_lock;
  assign unlock_i = lock_release_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int unsigned o);
    exp_t e;
    e.owner = 2'(o);
    e.gnt   = NREQ'(1 << o);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input logic lvl, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (owner_valid_o === lvl) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: owner_valid_o never reached %0b within 64 cycles", name, lvl);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      n_checks++;
      if (lock_acquire_o && lock_release_o) begin
        n_fail++;
        $display("FAIL strobe_overlap: acquire and release both high at %0t", $time);
      end
      if (owner_valid_o && !prev_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_grant: owner %0d gnt %b with none expected", owner_o, gnt_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (owner_o !== mon_e.owner || gnt_o !== mon_e.gnt) begin
            n_fail++;
            $display("FAIL grant_order: got owner %0d gnt %b expected owner %0d gnt %b",
                     owner_o, gnt_o, mon_e.owner, mon_e.gnt);
          end
        end
      end
      prev_valid = owner_valid_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tmo_seen;
    rst_n      = 1'b0;
    req_i      = 4'b1111;
    rel_i      = '0;
    block_lock = 1'b0;

    // Reset holds everything quiet even with all agents requesting.
    repeat (3) begin
      step();
      chk("reset_valid", owner_valid_o, 0);
      chk("reset_gnt", gnt_o, 0);
      chk("reset_acq", lock_acquire_o, 0);
    end
    rst_n = 1'b1;
    chk("post_reset_acq", lock_acquire_o, 0);
    chk("post_reset_valid", owner_valid_o, 0);
    req_i = '0;
    step();
    chk("idle_no_req_acq", lock_acquire_o, 0);

    // Fairness: all request, each owner releases immediately.
    expect_grant(0); expect_grant(1); expect_grant(2); expect_grant(3); expect_grant(0);
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid(1'b1, "fair_grant");
      if (k == 4) req_i = '0;
      rel_i = gnt_o;
      step();
      rel_i = '0;
      wait_valid(1'b0, "fair_release");
    end

    // Single grant with exact cycle timing; pointer is now 1.
    expect_grant(2);
    req_i = 4'b0100;
    step();
    chk("single_acq", lock_acquire_o, 1);
    chk("single_acq_gnt", gnt_o, 0);
    step();
    chk("single_gnt", gnt_o, 4'b0100);
    chk("single_owner", owner_o, 2);
    chk("single_valid", owner_valid_o, 1);
    chk("single_acq_drop", lock_acquire_o, 0);
    req_i = '0;
    rel_i = 4'b0100;
    step();
    rel_i = '0;
    chk("single_rel", lock_release_o, 1);
    chk("single_rel_gnt", gnt_o, 0);
    chk("single_rel_acq", lock_acquire_o, 0);
    step();
    chk("single_idle_valid", owner_valid_o, 0);
    chk("single_idle_rel", lock_release_o, 0);
    chk("single_idle_owner", owner_o, 0);

    // Blocked acquire: manager withholds lock_i for 20 cycles.
    block_lock = 1'b1;
    expect_grant(0);
    req_i = 4'b0001;
    step();
    for (int i = 0; i < 20; i++) begin
      chk("blocked_acq", {lock_acquire_o, owner_valid_o}, 2'b10);
      step();
    end
    block_lock = 1'b0;
    step();
    chk("blocked_then_held", owner_valid_o, 1);
    chk("blocked_owner", owner_o, 0);
    req_i = '0;
    rel_i = 4'b0001;
    step();
    rel_i = '0;
    wait_valid(1'b0, "blocked_release");

    // Foreign release is ignored; pointer is now 1.
    expect_grant(1);
    req_i = 4'b0010;
    wait_valid(1'b1, "foreign_grant");
    req_i = '0;
    rel_i = 4'b1000;
    step();
    rel_i = '0;
    repeat (3) begin
      chk("foreign_gnt", gnt_o, 4'b0010);
      chk("foreign_no_rel", lock_release_o, 0);
      step();
    end

    // Owner release with simultaneous new requests: release first, then pointer 2 wins.
    expect_grant(2);
    rel_i = 4'b0010;
    req_i = 4'b0101;
    step();
    rel_i = '0;
    chk("simul_rel", lock_release_o, 1);
    chk("simul_rel_gnt", gnt_o, 0);
    wait_valid(1'b0, "simul_idle");
    wait_valid(1'b1, "simul_regrant");
    chk("simul_owner", owner_o, 2);
    req_i = '0;
    rel_i = 4'b0100;
    step();
    rel_i = '0;
    wait_valid(1'b0, "simul_release");

    // Owner that never releases; pointer is now 3.
    expect_grant(3);
    req_i = 4'b1000;
    wait_valid(1'b1, "tmo_grant");
    req_i = '0;
`ifdef LOCK_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("tmo_held", {timeout_o, lock_release_o, owner_valid_o}, 3'b001);
      step();
    end
    chk("tmo_pulse", timeout_o, 1);
    chk("tmo_rel", lock_release_o, 1);
    chk("tmo_gnt", gnt_o, 0);
    step();
    chk("tmo_pulse_end", timeout_o, 0);
    wait_valid(1'b0, "tmo_release");
`else
    tmo_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (timeout_o !== 1'b0) tmo_seen = 1'b1;
      step();
    end
    chk("notmo_valid", owner_valid_o, 1);
    chk("notmo_gnt", gnt_o, 4'b1000);
    chk("notmo_rel", lock_release_o, 0);
    chk("notmo_pulse", tmo_seen, 0);
    rel_i = 4'b1000;
    step();
    rel_i = '0;
    wait_valid(1'b0, "notmo_release");
`endif

    repeat (4) step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cache_lock_arbiter.md
Name: sd_cache_lock_arbiter

Overview:
- Sits directly upstream of the SD cache manager lock logic.
- Arbitrates up to NUM_REQ agents competing for the SD cache lock using round-robin priority.
- Drives the manager's lock_acquire/lock_release strobes, consumes its lock/unlock qualifiers, and reports the current owner.
- Ownership defaults to "none" out of reset; the cache is never treated as locked without a completed acquire handshake.

Parameters:
- NUM_REQ, 4, number of requesting agents (2..16).
- OWNER_W, $clog2(NUM_REQ), owner index width (derived; do not override).
- TIMEOUT_CYCLES, 1024, maximum HELD duration before forced release (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_i  in  NUM_REQ  per-agent lock request level; held until granted.
- rel_i  in  NUM_REQ  per-agent release pulse; honoured only from the current owner.
- gnt_o  out  NUM_REQ  one-hot grant; high while the agent owns the lock.
- owner_o  out  OWNER_W  index of the current owner; 0 when owner_valid_o=0.
- owner_valid_o  out  1  lock is held by owner_o.
- lock_acquire_o  out  1  acquire strobe to the cache manager.
- lock_release_o  out  1  release strobe to the cache manager.
- lock_i  in  1  manager acknowledge: acquire accepted (acquire & unlocked).
- unlock_i  in  1  manager acknowledge: release accepted (release & locked).
- timeout_o  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all outputs 0; round-robin pointer=0; timeout counter=0.
  - Reset mid-operation abandons any handshake with no release strobe. The manager is reset in the same domain.
- FSM states:
  - IDLE: when any req_i bit is set, pick the winner by round-robin starting at pointer, latch the winner index, go to ACQ.
  - ACQ:
    - lock_acquire_o=1 every cycle.
    - On lock_i=1: go to HELD; gnt_o[winner]=1 and owner_valid_o=1 from the next cycle; pointer=winner+1 (mod NUM_REQ).
    - If the winner drops req_i before lock_i: deassert acquire and return to IDLE; the pointer is unchanged.
  - HELD:
    - gnt_o and owner asserted.
    - rel_i[owner]=1 → REL.
    - rel_i from non-owners is ignored.
    - Other req_i bits wait.
  - REL:
    - lock_release_o=1 every cycle; gnt_o drops on entry.
    - On unlock_i=1 → IDLE; owner_valid_o=0 from the next cycle.
- Latency:
  - Minimum grant is 2 cycles after req_i (IDLE→ACQ, ACQ ack).
  - A new arbitration starts in the cycle after return to IDLE. No back-to-back ownership without passing through IDLE.
- lock_acquire_o and lock_release_o are never high together. Neither is asserted in IDLE or HELD.
- Simultaneous rel_i[owner] and a new req_i: release wins; the new request is arbitrated after IDLE.
- An unexpected lock_i or unlock_i in any other state is ignored (no state change).
- Round-robin wraps from NUM_REQ-1 to 0. A single persistent requester is re-granted every round.

Optional Feature:
- LOCK_TIMEOUT_EN:
  - Defined:
    - The counter increments each HELD cycle and clears on HELD entry.
    - When the count reaches TIMEOUT_CYCLES-1, the FSM forces REL.
    - timeout_o pulses 1 cycle on that transition; gnt_o drops.
  - Undefined:
    - No counter is built; timeout_o is tied 0.
    - HELD persists until the owner releases.

Decomposition:
- Shared package sd_cache_lock_pkg:
  - state enum (IDLE, ACQ, HELD, REL) as a 2-bit typedef.
  - default NUM_REQ and TIMEOUT_CYCLES localparams.
- Sub-module rr_arbiter:
  - Combinational one-hot pick from req vector and pointer.
  - Returns index and valid.
  - Reusable by other piton SD stages.

Test Plan:
- Reset default: assert rst_n=0 for 3 cycles with req_i=4'b1111 → owner_valid_o=0, gnt_o=0, lock_acquire_o=0 throughout reset and on the first cycle after.
- Single grant: req_i=4'b0100, lock_i=1 in ACQ → lock_acquire_o high 1 cycle, gnt_o=4'b0100 and owner_o=2 two cycles after req; rel_i[2] pulse with unlock_i=1 → IDLE, owner_valid_o=0.
- Fairness: req_i=4'b1111 held, each owner releases immediately → grant order 0,1,2,3,0.
- Blocked acquire: lock_i held 0 for 20 cycles → stay in ACQ with lock_acquire_o=1 all 20 cycles; lock_i=1 → HELD.
- Foreign release: owner 1, rel_i=4'b1000 → no state change, gnt_o stays 4'b0010.
- Timeout (LOCK_TIMEOUT_EN, TIMEOUT_CYCLES=16): owner never releases → timeout_o pulses after 16 HELD cycles, lock_release_o asserts; without the macro → still HELD after 100 cycles.
